spell_shift_host: RTL and testbench
===================================

// Module: spell_shift_host
// PURPOSE
//  Host-side master for the SPELL core's serial register-access port (load/dump/shift_in/shift_out/reg_sel).
//  Converts parallel read/write commands into the dump -> shift -> load bit sequence; returns the captured old value.
//  Sits in the debug/loader path, driving the core's access pins; the core must be halted (run low) while a command runs.
// PARAMETERS
//  SAMPLE_DELAY  0  clocks between the core's shift-register edge and i_shift_out validity here (IO/sync stages); 0..3
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  cmd_valid     in   1  command request
//  cmd_ready     out  1  command accepted when cmd_valid && cmd_ready at posedge clk
//  cmd_write     in   1  1 = write cmd_wdata to the register, 0 = read only
//  cmd_reg       in   2  register select: 0 PC, 1 SP, 2 exec, 3 stack top
//  cmd_wdata     in   8  write data, MSB first on the wire; ignored for reads
//  rsp_valid     out  1  response available; held until rsp_ready
//  rsp_ready     in   1  response consumed when rsp_valid && rsp_ready at posedge clk
//  rsp_rdata     out  8  register value captured by the dump (old value for writes)
//  o_reg_sel     out  2  to core reg_sel
//  o_dump        out  1  to core dump strobe; one cycle
//  o_load        out  1  to core load strobe; one cycle
//  o_shift_in    out  1  to core shift_in
//  i_shift_out   in   1  from core shift_out
// BEHAVIOUR
//  Core port contract: dump copies reg[reg_sel] into the core's 8-bit shift register. In each cycle with load=dump=0,
//   the shift register shifts left by one bit; shift_in enters at the LSB and the MSB appears on shift_out.
//   load copies the shift register into reg[reg_sel].
//  All core-facing outputs and rsp_* are registered. Reset (async): state IDLE; cmd_ready=1 after reset release;
//   rsp_valid=0, rsp_rdata=0, o_reg_sel=0, o_dump=0, o_load=0, o_shift_in=0, counters=0.
//  FSM: IDLE -> DUMP -> SHIFT -> (LOAD if write) -> RESP -> IDLE.
//   IDLE:  cmd_ready=1. On accept (edge e0), latch cmd_write/cmd_reg/cmd_wdata. Next state is DUMP.
//   DUMP:  one cycle; o_dump=1; o_reg_sel=latched reg.
//   SHIFT: N=8+SAMPLE_DELAY cycles, cnt 0..N-1.
//          o_shift_in=0 for cnt<SAMPLE_DELAY; otherwise wdata[7-(cnt-SAMPLE_DELAY)]. Reads always drive 0.
//          For cnt>=SAMPLE_DELAY, sample i_shift_out at the end of the cycle into rdata, MSB first (shift-left capture).
//          The core therefore holds wdata after the final shift.
//   LOAD:  writes only; one cycle; o_load=1.
//   RESP:  rsp_valid=1, rsp_rdata stable. On rsp_ready, go to IDLE; rsp_valid drops on the same edge.
//  o_reg_sel holds the latched value from DUMP through LOAD/RESP. It changes only on the next accept.
//  o_dump and o_load are never both high, and never high outside DUMP/LOAD.
//  Latency, D=SAMPLE_DELAY, accept at e0:
//   read:  rsp_valid high after edge e(9+D)
//   write: o_load high during cycle after e(9+D); rsp_valid high after e(10+D)
//  Boundaries:
//   cmd_ready=0 in every state but IDLE; cmd_valid outside IDLE is ignored and not queued.
//   rsp_ready low stalls in RESP indefinitely; core outputs stay idle (dump=load=shift_in=0).
//   Note: the core keeps shifting while stalled, which is harmless because the write has already been loaded.
//   Back-to-back: rsp handshake at edge e moves to IDLE. A command may be accepted at e+1 (one idle cycle minimum).
//   Reset mid-command: immediate return to reset values; no load is issued, so core registers are unchanged.
//   cmd_reg and cmd_wdata changes after accept have no effect.
// TESTING (bench includes a behavioural core model per the port contract, with SAMPLE_DELAY flops on shift_out)
//  1 D=0, core PC=0xA5, read reg0 -> rsp_valid after e9; rsp_rdata=0xA5; o_load never high; PC still 0xA5.
//  2 D=0, SP=0x3C, write reg1 wdata=0x81 -> rsp_rdata=0x3C after e10; model SP=0x81; o_load one cycle, o_dump one cycle.
//  3 D=2, exec=0xFF, write reg2 wdata=0x00 -> rsp_rdata=0xFF after e12; exec=0x00; first 2 shift_in bits 0.
//  4 Hold rsp_ready=0 for 20 cycles with cmd_valid=1 -> cmd_ready stays 0, rsp_rdata stable. Release -> next cmd accepted
//    one cycle after the rsp handshake.
//  5 Assert rst_n=0 during SHIFT cnt=4 of write 0x55 to reg3 (top=0x11) -> outputs at reset values at once; top stays 0x11.
//  6 Four back-to-back writes 0x01,0x02,0x04,0x08 to reg0..3, then four reads -> read data matches; reg_sel matches per command.

Source files
------------

// File: rtl/spell_shift_host.sv
// Host master for the SPELL serial register port: dump -> shift (capture old value, insert new) -> load.
// Read response 9+D cycles after accept, write 10+D; rsp_ready low parks in RESP with core pins idle, cmd_ready low when busy.
module spell_shift_host #(
  parameter int SAMPLE_DELAY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] o_reg_sel,
  output logic       o_dump,
  output logic       o_load,
  output logic       o_shift_in,
  input  logic       i_shift_out
);

  typedef enum logic [2:0] {IDLE, DUMP, SHIFT, LOAD, RESP} state_t;

  localparam logic [3:0] DLY  = 4'(SAMPLE_DELAY);
  localparam logic [3:0] LAST = 4'(SAMPLE_DELAY + 7);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       wr_q;
  logic [7:0] wsh_q;
  logic       dump_nxt, load_nxt, rsp_valid_nxt, shift_in_nxt, data_take;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dump_nxt      = 1'b0;
    load_nxt      = 1'b0;
    rsp_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = DUMP;
          dump_nxt  = 1'b1;
        end
      end
      DUMP: begin
        state_nxt = SHIFT;
        cnt_nxt   = 4'd0;
      end
      SHIFT: begin
        if (cnt == LAST) begin
          cnt_nxt = 4'd0;
          if (wr_q) begin
            state_nxt = LOAD;
            load_nxt  = 1'b1;
          end else begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      LOAD: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
        else           rsp_valid_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // The first DLY shift slots carry zeros so the write data lines up with the delayed capture window.
    data_take    = (state_nxt == SHIFT) && wr_q && (cnt_nxt >= DLY);
    shift_in_nxt = data_take ? wsh_q[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      wsh_q      <= 8'd0;
      o_reg_sel  <= 2'd0;
      o_dump     <= 1'b0;
      o_load     <= 1'b0;
      o_shift_in <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_dump     <= dump_nxt;
      o_load     <= load_nxt;
      o_shift_in <= shift_in_nxt;
      rsp_valid  <= rsp_valid_nxt;
      if (state == IDLE && cmd_valid) begin
        wr_q      <= cmd_write;
        wsh_q     <= cmd_wdata;
        o_reg_sel <= cmd_reg;
      end else if (data_take) begin
        wsh_q <= {wsh_q[6:0], 1'b0};
      end
      if (state == SHIFT && cnt >= DLY) begin
        rsp_rdata <= {rsp_rdata[6:0], i_shift_out};
      end
    end
  end

endmodule

// File: tb/tb_spell_shift_host.sv
// Directed bench for spell_shift_host: two instances (D=0, D=2) each driving a behavioural core model.
module tb_spell_shift_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_write [2];
  logic [1:0] cmd_reg   [2];
  logic [7:0] cmd_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic [1:0] reg_sel   [2];
  logic       dump      [2];
  logic       load      [2];
  logic       shift_in  [2];
  logic       shift_out [2];

  logic [7:0]  creg [2][4];
  logic [7:0]  sr   [2];
  logic [1:0]  dly;
  logic [15:0] slog [2];
  int          ndump [2];
  int          nload [2];
  int          nboth = 0;

  logic       pre_en = 1'b0;
  int         pre_k = 0;
  logic [1:0] pre_sel = 2'd0;
  logic [7:0] pre_val = 8'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spell_shift_host #(.SAMPLE_DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_reg(cmd_reg[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .o_reg_sel(reg_sel[0]), .o_dump(dump[0]), .o_load(load[0]),
    .o_shift_in(shift_in[0]), .i_shift_out(shift_out[0])
  );

  spell_shift_host #(.SAMPLE_DELAY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_reg(cmd_reg[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .o_reg_sel(reg_sel[1]), .o_dump(dump[1]), .o_load(load[1]),
    .o_shift_in(shift_in[1]), .i_shift_out(shift_out[1])
  );

  // Core model: dump/load/shift per the port contract; instance 1 sees shift_out through two flops.
  assign shift_out[0] = sr[0][7];
  assign shift_out[1] = dly[1];

  initial begin
    for (int k = 0; k < 2; k++) begin
      sr[k] = 8'd0; slog[k] = 16'd0; ndump[k] = 0; nload[k] = 0;
      for (int r = 0; r < 4; r++) creg[k][r] = 8'd0;
    end
    dly = 2'd0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dump[k])      sr[k] <= creg[k][reg_sel[k]];
      else if (load[k]) creg[k][reg_sel[k]] <= sr[k];
      else              sr[k] <= {sr[k][6:0], shift_in[k]};
      if (pre_en && pre_k == k) creg[k][pre_sel] <= pre_val;
      slog[k] <= {slog[k][14:0], shift_in[k]};
      if (dump[k]) ndump[k] <= ndump[k] + 1;
      if (load[k]) nload[k] <= nload[k] + 1;
      if (dump[k] && load[k]) nboth <= nboth + 1;
    end
    dly <= {dly[0], sr[1][7]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int k, input logic [1:0] sel, input logic [7:0] val);
    pre_en = 1'b1; pre_k = k; pre_sel = sel; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input int k, input logic wr, input logic [1:0] rg, input logic [7:0] wd);
    check("ready_idle", cmd_ready[k], 1);
    cmd_valid[k] = 1'b1; cmd_write[k] = wr; cmd_reg[k] = rg; cmd_wdata[k] = wd;
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0; cmd_reg[k] = ~rg; cmd_wdata[k] = ~wd;
    check("dump_after_accept", dump[k], 1);
    check("reg_sel_dump", reg_sel[k], rg);
    check("ready_busy", cmd_ready[k], 0);
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid[k]) check("rsp_timeout", rsp_valid[k], 1);
  endtask

  task automatic take_rsp(input int k);
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    check("rsp_valid_drop", rsp_valid[k], 0);
    check("ready_after_rsp", cmd_ready[k], 1);
  endtask

  task automatic do_cmd(input int k, input logic wr, input logic [1:0] rg, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input int exp_lat, output logic [15:0] lg);
    int d0, l0, lat;
    d0 = ndump[k]; l0 = nload[k];
    issue(k, wr, rg, wd);
    wait_rsp(k, lat);
    lg = slog[k];
    check("latency", lat, exp_lat);
    check("rdata", rsp_rdata[k], exp_rd);
    check("reg_sel_resp", reg_sel[k], rg);
    take_rsp(k);
    check("dump_count", ndump[k] - d0, 1);
    check("load_count", nload[k] - l0, {31'd0, wr});
  endtask

  initial begin
    logic [15:0] lg;
    int lat, l0, stall_bad;
    logic [7:0] old [4];
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_reg[k] = 2'd0;
      cmd_wdata[k] = 8'd0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_cmd_ready", cmd_ready[k], 1);
      check("rst_rsp_valid", rsp_valid[k], 0);
      check("rst_rsp_rdata", rsp_rdata[k], 0);
      check("rst_reg_sel", reg_sel[k], 0);
      check("rst_dump", dump[k], 0);
      check("rst_load", load[k], 0);
      check("rst_shift_in", shift_in[k], 0);
    end
    @(posedge clk); #1;

    // 1: D=0 read PC
    preload(0, 2'd0, 8'hA5);
    do_cmd(0, 1'b0, 2'd0, 8'h00, 8'hA5, 9, lg);
    check("t1_pc_kept", creg[0][0], 8'hA5);

    // 2: D=0 write SP
    preload(0, 2'd1, 8'h3C);
    do_cmd(0, 1'b1, 2'd1, 8'h81, 8'h3C, 10, lg);
    check("t2_sp_new", creg[0][1], 8'h81);
    check("t2_shift_bits", lg[8:0], 9'h102);

    // 3: D=2 write exec, then a non-trivial pattern and a read-back
    preload(1, 2'd2, 8'hFF);
    do_cmd(1, 1'b1, 2'd2, 8'h00, 8'hFF, 12, lg);
    check("t3_exec_new", creg[1][2], 8'h00);
    check("t3_first2_zero", lg[10:9], 2'b00);
    do_cmd(1, 1'b1, 2'd2, 8'hC3, 8'h00, 12, lg);
    check("t3_exec_c3", creg[1][2], 8'hC3);
    check("t3_shift_bits", lg[10:0], 11'h186);
    do_cmd(1, 1'b0, 2'd2, 8'h5A, 8'hC3, 11, lg);
    check("t3_exec_kept", creg[1][2], 8'hC3);

    // 4: stall in RESP with a pending command
    issue(0, 1'b0, 2'd0, 8'h00);
    wait_rsp(0, lat);
    check("t4_lat", lat, 9);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_reg[0] = 2'd1; cmd_wdata[0] = 8'h77;
    stall_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cmd_ready[0] || !rsp_valid[0] || rsp_rdata[0] != 8'hA5 || dump[0] || load[0] || shift_in[0])
        stall_bad++;
    end
    check("t4_stall", stall_bad, 0);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("t4_rsp_drop", rsp_valid[0], 0);
    check("t4_ready", cmd_ready[0], 1);
    check("t4_no_dump_yet", dump[0], 0);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    check("t4_accept_next", dump[0], 1);
    check("t4_reg_sel", reg_sel[0], 1);
    wait_rsp(0, lat);
    check("t4_lat2", lat, 10);
    check("t4_rdata2", rsp_rdata[0], 8'h81);
    take_rsp(0);
    check("t4_sp_new", creg[0][1], 8'h77);

    // 5: reset during SHIFT cnt=4
    preload(0, 2'd3, 8'h11);
    l0 = nload[0];
    issue(0, 1'b1, 2'd3, 8'h55);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid[0], 0);
    check("t5_rdata", rsp_rdata[0], 0);
    check("t5_reg_sel", reg_sel[0], 0);
    check("t5_dump", dump[0], 0);
    check("t5_load", load[0], 0);
    check("t5_shift_in", shift_in[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_ready", cmd_ready[0], 1);
    check("t5_top_kept", creg[0][3], 8'h11);
    check("t5_no_load", nload[0] - l0, 0);

    // 6: back-to-back writes then reads
    for (int i = 0; i < 4; i++) begin
      old[i] = 8'h10 * (i + 1);
      preload(0, 2'(i), old[i]);
    end
    for (int i = 0; i < 4; i++) do_cmd(0, 1'b1, 2'(i), 8'(1 << i), old[i], 10, lg);
    for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 2'(i), 8'hEE, 8'(1 << i), 9, lg);
    for (int i = 0; i < 4; i++) check("t6_core_reg", creg[0][i], 8'(1 << i));

    check("dump_load_overlap", nboth, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
